regfile_read_arbiter: RTL
=========================

# regfile_read_arbiter

Round-robin arbiter that shares one register-file read path (the 32-to-1 register select mux) between several requesters, such as decode read ports, a debug port and a forwarding-check port. It grants one requester per cycle, drives the mux `Selector` with the winner's register address, and captures the mux output into a registered read-data return with a one-hot valid. It sits between the requesting stages and the register-file read mux.

## Interface
- `DATA_WIDTH`, 32, width of register data.
- `NUM_REQ`, 4, number of requesters; legal range 2..8.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `Req`  in  NUM_REQ  per-requester read request, level.
- `Addr`  in  5*NUM_REQ  packed register addresses; requester i uses `Addr[5i+4:5i]`.
- `Read_Data_In`  in  DATA_WIDTH  shared mux output, combinational from `Selector`.
- `Selector`  out  5  register select driven to the shared mux (registered).
- `Grant`  out  NUM_REQ  one-hot grant pulse (registered).
- `Rd_Valid`  out  NUM_REQ  one-hot read-data valid pulse (registered).
- `Rd_Data`  out  DATA_WIDTH  captured read data (registered).

## Operation
- Internal state: round-robin pointer `Last` (index of most recent winner, width clog2(NUM_REQ)).
- Eligibility at each edge: `Eligible = Req & ~Grant`. A requester whose grant pulse is high in the current cycle is excluded at that edge.
- Priority search starts at `(Last+1) mod NUM_REQ` and wraps upward. The first eligible index wins.
- When there is a winner w at an edge: `Grant` <= onehot(w), `Selector` <= `Addr[w]`, `Last` <= w.
- When there is no eligible requester: `Grant` <= 0, `Selector` and `Last` hold.
- Data capture at each edge: `Rd_Valid` <= `Grant`, `Rd_Data` <= `Read_Data_In` when `Grant != 0`; otherwise `Rd_Data` holds.
- Requester protocol:
  - Hold `Req` and `Addr` stable until `Grant[i]` is seen high.
  - The `Addr` used is the value sampled at the winning edge.
  - If `Req` stays high after the grant pulse, it is a new request.
- A single requester holding `Req` high is therefore granted every other cycle. With two or more requesters, a grant issues every cycle.
- At most one bit of `Grant` and at most one bit of `Rd_Valid` is ever set.
- Reset values: `Grant`=0, `Rd_Valid`=0, `Selector`=0, `Rd_Data`=0, `Last`=NUM_REQ-1, so requester 0 has top priority after reset.
- Reset asserted mid-operation clears all state immediately. In-flight grants are discarded and never produce `Rd_Valid`. Requesters must re-request.
- Requests and address changes arriving in the same cycle as a grant are simply sampled at the next edge. There is no special case.

## Timing
- Edge k: `Req[i]` sampled and wins.
- Cycle k+1: `Grant[i]`=1 and `Selector`=`Addr[i]`. The mux settles combinationally within this cycle.
- Edge k+2: `Read_Data_In` captured.
- Cycle k+2: `Rd_Valid[i]`=1 and `Rd_Data` valid.
- Latency from request sampled to data valid is 2 cycles.
- Throughput is 1 read per cycle aggregate; 1 per 2 cycles per requester.
- `Rd_Data` remains stable after the valid pulse until the next capture.
- No combinational path from `Req`/`Addr` to any output. The only path through the block is `Selector` (registered) -> external mux -> `Read_Data_In` -> `Rd_Data` register.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle with random inputs -> all outputs 0 immediately; after release with `Req`=4'b1111, first `Grant`=4'b0001.
- **Single read:** `Req`=4'b0001, `Addr[4:0]`=5, register 5 holds 0xA5A5_0005 -> `Grant`=0001 and `Selector`=5 one cycle after sampling edge; `Rd_Valid`=0001 with `Rd_Data`=0xA5A5_0005 the following cycle.
- **Full contention:** `Req`=4'b1111 held for 8 cycles, `Addr`=registers 1,2,3,4 -> `Grant` sequence 0001,0010,0100,1000,0001,…; `Rd_Data` sequence reg1,reg2,reg3,reg4,….
- **Lone requester held:** `Req`=4'b0100 held high -> `Grant` alternates 0100,0000,0100,…; `Rd_Valid[2]` pulses every other cycle.
- **Round-robin pointer:** after a grant to requester 1, `Req`=4'b1011 -> next grants 1000 then 0001 then 0010.
- **Reset during flight:** `reset` pulsed in the cycle `Grant`=0010 -> `Rd_Valid` stays 0; `Rd_Data`=0; next grant after release follows priority from requester 0.

Source files
------------

// File: rtl/regfile_read_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_read_arbiter
//   Round-robin arbiter sharing one register-file read mux between NUM_REQ
//   requesters. One grant per cycle; the winner's address is registered onto
//   selector_o, and the mux output is captured one cycle later into
//   rd_data_o with a one-hot rd_valid_o.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   req_i        [NUM_REQ]     per-requester level request
//   addr_i       [5*NUM_REQ]   packed addresses, requester i at [5i+4:5i]
//   read_data_i  [DATA_WIDTH]  shared mux output (combinational from selector_o)
//   selector_o   [5]           registered register select to the mux
//   grant_o      [NUM_REQ]     registered one-hot grant pulse
//   rd_valid_o   [NUM_REQ]     registered one-hot read-data valid pulse
//   rd_data_o    [DATA_WIDTH]  captured read data, holds between captures
// ----------------------------------------------------------------------------
module regfile_read_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [5*NUM_REQ-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]  read_data_i,
    output logic [4:0]             selector_o,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic [NUM_REQ-1:0]     rd_valid_o,
    output logic [DATA_WIDTH-1:0]  rd_data_o
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]      last_q, last_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic [4:0]            sel_q, sel_d;
    logic [NUM_REQ-1:0]    rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;

    logic [NUM_REQ-1:0]    eligible;
    logic [PTR_W-1:0]      cand_idx;
    logic [PTR_W-1:0]      win_idx;
    logic                  found;

    // Priority search: walk upward from last_q+1, wrapping, first eligible
    // index wins. A requester currently holding its grant pulse is masked so a
    // level request is treated as a fresh request only after the pulse.
    always_comb begin
        eligible = req_i & ~grant_q;
        found    = 1'b0;
        win_idx  = last_q;
        cand_idx = last_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_idx = PTR_W'((int'(last_q) + k) % NUM_REQ);
            if (!found && eligible[cand_idx]) begin
                found   = 1'b1;
                win_idx = cand_idx;
            end
        end
    end

    always_comb begin
        grant_d = '0;
        sel_d   = sel_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (found && (win_idx == PTR_W'(i))) begin
                grant_d[i] = 1'b1;
                sel_d      = addr_i[5*i +: 5];
            end
        end
        last_d = found ? win_idx : last_q;
    end

    // last_q resets to NUM_REQ-1 so requester 0 is searched first.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q     <= PTR_W'(NUM_REQ - 1);
            grant_q    <= '0;
            sel_q      <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
        end else begin
            last_q     <= last_d;
            grant_q    <= grant_d;
            sel_q      <= sel_d;
            // The mux has had the whole grant cycle to settle on sel_q.
            rd_valid_q <= grant_q;
            if (|grant_q) begin
                rd_data_q <= read_data_i;
            end
        end
    end

    assign selector_o = sel_q;
    assign grant_o    = grant_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;

endmodule
